// File: rtl/slow_unpacker.sv
// slow_unpacker: fetches one frame of 12-bit orbit words from the shared word
// RAM, one read per word, strips the {0, data[7:0], flags[1:0], 0} framing and
// presents each byte/flag pair on a valid/ready output.
module slow_unpacker #(
  parameter int ADDR_W    = 11,
  parameter int BASE_OFS  = 0,
  parameter int FRAME_LEN = 16,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              SW,
  input  logic [11:0]       rdData,
  input  logic              iReady,
  output logic              RE,
  output logic [ADDR_W-1:0] rdAddr,
  output logic [7:0]        oData,
  output logic [1:0]        oFlags,
  output logic              oValid,
  output logic              busy,
  output logic              frameDone,
  output logic [7:0]        errCount
);

  localparam int OFS_W = ADDR_W - 1;
  localparam int CNT_W = 10;  // FRAME_LEN-1 never exceeds 1023

  typedef enum logic [1:0] {IDLE, READ, WAITQ, HOLD} state_t;

  state_t              r_state, w_state;
  logic [1:0]          r_sw_sync;
  logic                r_bank, w_bank;
  logic [OFS_W-1:0]    r_offset, w_offset;
  logic [CNT_W-1:0]    r_count, w_count;
  logic [1:0]          r_lat, w_lat;
  logic                r_re, w_re;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [7:0]          r_data, w_data;
  logic [1:0]          r_flags, w_flags;
  logic                r_valid, w_valid;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic [7:0]          r_err, w_err;
  logic                w_bad_word;

  assign w_bad_word = rdData[11] | rdData[0];

  // Two-flop synchroniser for the asynchronous bank select.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly as the hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sw_sync <= 2'b00;
    else     r_sw_sync <= {r_sw_sync[0], SW};
  end

  // Next-state and next-output logic for the frame fetch FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred; pulses (RE, frameDone) default low.
    w_state  = r_state;
    w_bank   = r_bank;
    w_offset = r_offset;
    w_count  = r_count;
    w_lat    = r_lat;
    w_re     = 1'b0;
    w_addr   = r_addr;
    w_data   = r_data;
    w_flags  = r_flags;
    w_valid  = r_valid;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_err    = r_err;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_bank   = r_sw_sync[1];
          w_offset = OFS_W'(BASE_OFS);
          w_count  = '0;
          w_busy   = 1'b1;
          w_re     = 1'b1;
          w_addr   = {r_sw_sync[1], OFS_W'(BASE_OFS)};
          w_lat    = '0;
          w_state  = WAITQ;
        end
      end
      READ: begin
        w_re    = 1'b1;
        w_addr  = {r_bank, r_offset};
        w_lat   = '0;
        w_state = WAITQ;
      end
      WAITQ: begin
        // rdData is valid RD_LAT edges after the RE edge; capture on the next.
        if (r_lat == 2'(RD_LAT)) begin
          w_data  = rdData[10:3];
          w_flags = rdData[2:1];
          w_valid = 1'b1;
          if (w_bad_word && (r_err != 8'hFF)) w_err = r_err + 8'd1;
          w_state = HOLD;
        end else begin
          w_lat = r_lat + 2'd1;
        end
      end
      HOLD: begin
        if (r_valid && iReady) begin
          w_valid = 1'b0;
          if (r_count == CNT_W'(FRAME_LEN - 1)) begin
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_state = IDLE;
          end else begin
            w_count  = r_count + CNT_W'(1);
            // Offset wraps within the bank; the bank bit is never carried into.
            w_offset = r_offset + OFS_W'(1);
            w_state  = READ;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // State and registered-output update; reset returns everything to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bank   <= 1'b0;
      r_offset <= OFS_W'(BASE_OFS);
      r_count  <= '0;
      r_lat    <= '0;
      r_re     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state;
      r_bank   <= w_bank;
      r_offset <= w_offset;
      r_count  <= w_count;
      r_lat    <= w_lat;
      r_re     <= w_re;
      r_addr   <= w_addr;
      r_data   <= w_data;
      r_flags  <= w_flags;
      r_valid  <= w_valid;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
    end
  end

  assign RE        = r_re;
  assign rdAddr    = r_addr;
  assign oData     = r_data;
  assign oFlags    = r_flags;
  assign oValid    = r_valid;
  assign busy      = r_busy;
  assign frameDone = r_done;
  assign errCount  = r_err;

endmodule

// File: tb/tb_slow_unpacker.sv
// tb_slow_unpacker: directed bench for slow_unpacker. Instance 0 uses default
// parameters; instance 1 uses BASE_OFS=1020, FRAME_LEN=8 to exercise the
// offset wrap. Both read the same word RAM model (read latency 1).
module tb_slow_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw;
  logic        start   [2];
  logic        iready  [2];
  logic        re      [2];
  logic [10:0] rd_addr [2];
  logic [11:0] rd_data [2];
  logic [7:0]  odata   [2];
  logic [1:0]  oflags  [2];
  logic        ovalid  [2];
  logic        busy    [2];
  logic        fdone   [2];
  logic [7:0]  errc    [2];

  logic [11:0] mem [2048];

  int checks = 0;
  int errors = 0;
  int err_exp = 0;

  always #5 clk = ~clk;

  slow_unpacker u_a (
    .clk(clk), .rst(rst), .start(start[0]), .SW(sw), .rdData(rd_data[0]),
    .iReady(iready[0]), .RE(re[0]), .rdAddr(rd_addr[0]), .oData(odata[0]),
    .oFlags(oflags[0]), .oValid(ovalid[0]), .busy(busy[0]),
    .frameDone(fdone[0]), .errCount(errc[0])
  );

  slow_unpacker #(.BASE_OFS(1020), .FRAME_LEN(8)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .SW(sw), .rdData(rd_data[1]),
    .iReady(iready[1]), .RE(re[1]), .rdAddr(rd_addr[1]), .oData(odata[1]),
    .oFlags(oflags[1]), .oValid(ovalid[1]), .busy(busy[1]),
    .frameDone(fdone[1]), .errCount(errc[1])
  );

  // Word RAM model: one read port per instance, data valid one edge after RE.
  always @(posedge clk) begin
    if (re[0]) rd_data[0] <= mem[rd_addr[0]];
    if (re[1]) rd_data[1] <= mem[rd_addr[1]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_sw(input logic v);
    sw = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic fill(input logic bank, input int base, input int n, input logic [11:0] word);
    for (int i = 0; i < n; i++) mem[{bank, 10'((base + i) % 1024)}] = word;
  endtask

  task automatic add_err(input int n);
    err_exp = (err_exp + n > 255) ? 255 : err_exp + n;
  endtask

  // Pulse start, then follow the frame at every negedge: RE addresses, each
  // accepted word, and frameDone one clock after the last accept.
  task automatic run_frame(input int d, input logic bank, input int base, input int n,
                           input logic [7:0] ed, input logic [1:0] ef);
    int  re_n = 0;
    int  acc = 0;
    int  last_acc = -10;
    bit  done = 0;
    @(negedge clk);
    start[d]  = 1'b1;
    iready[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check("busy_at_start", busy[d], 1'b1);
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (re[d]) begin
        check("re_addr", rd_addr[d], {bank, 10'((base + re_n) % 1024)});
        re_n++;
      end
      if (ovalid[d] && iready[d]) begin
        check("odata", odata[d], ed);
        check("oflags", oflags[d], ef);
        acc++;
        last_acc = cyc;
      end
      if (fdone[d]) begin
        done = 1;
        check("done_delay", cyc, last_acc + 1);
        check("busy_at_done", busy[d], 1'b0);
      end
      if (!done) @(negedge clk);
    end
    check("frame_done_seen", done, 1'b1);
    check("words_accepted", acc, n);
    check("re_pulses", re_n, n);
    @(negedge clk);
    check("done_one_cycle", fdone[d], 1'b0);
  endtask

  // Keep iReady high until frameDone (bounded).
  task automatic drain(input int d);
    bit done = 0;
    iready[d] = 1'b1;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clk);
      if (fdone[d]) done = 1;
    end
    check("drain_done", done, 1'b1);
  endtask

  typedef struct {
    logic        sw;
    logic [11:0] word;
    logic [7:0]  exp_data;
    logic [1:0]  exp_flags;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0, 12'h7F8, 8'hFF, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 12'h556, 8'hAA, 2'b11, 1'b0};
    vecs[2] = '{1'b0, 12'h3A5, 8'h74, 2'b10, 1'b1};
    vecs[3] = '{1'b1, 12'h801, 8'h00, 2'b00, 1'b1};
    vecs[4] = '{1'b0, 12'h802, 8'h00, 2'b01, 1'b1};
    vecs[5] = '{1'b1, 12'h7FE, 8'hFF, 2'b11, 1'b0};

    for (int i = 0; i < 2048; i++) mem[i] = 12'h000;
    rst = 1'b1;
    sw  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d]  = 1'b0;
      iready[d] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_re", re[0], 1'b0);
    check("rst_addr", rd_addr[0], 11'h000);
    check("rst_ovalid", ovalid[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", fdone[0], 1'b0);
    check("rst_err", errc[0], 8'h00);
    check("rst_b_busy", busy[1], 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven frames: one full frame per vector, bank from SW
    for (int v = 0; v < 6; v++) begin
      set_sw(vecs[v].sw);
      fill(vecs[v].sw, 0, 16, vecs[v].word);
      run_frame(0, vecs[v].sw, 0, 16, vecs[v].exp_data, vecs[v].exp_flags);
      if (vecs[v].exp_err) add_err(16);
      check("err_count", errc[0], err_exp);
    end

    // Consumer stall in HOLD; SW toggled mid-frame must not change the bank
    set_sw(1'b0);
    fill(1'b0, 0, 16, 12'h3A5);
    @(negedge clk);
    start[0]  = 1'b1;
    iready[0] = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    for (int cyc = 0; cyc < 20 && !ovalid[0]; cyc++) @(negedge clk);
    check("hold_valid", ovalid[0], 1'b1);
    sw = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_valid_stable", ovalid[0], 1'b1);
      check("hold_data_stable", odata[0], 8'h74);
      check("hold_flags_stable", oflags[0], 2'b10);
      check("hold_no_re", re[0], 1'b0);
    end
    iready[0] = 1'b1;
    @(negedge clk);
    check("hold_accept", ovalid[0], 1'b0);
    @(negedge clk);
    check("hold_next_re", re[0], 1'b1);
    check("hold_next_addr_bank0", rd_addr[0], 11'h001);
    drain(0);
    add_err(16);
    check("err_after_stall", errc[0], err_exp);

    // Error counter saturation: 19 frames of 12'h801 (304 bad words)
    set_sw(1'b1);
    fill(1'b1, 0, 16, 12'h801);
    for (int f = 0; f < 19; f++) begin
      run_frame(0, 1'b1, 0, 16, 8'h00, 8'h00);
      add_err(16);
      check("err_sat_track", errc[0], err_exp);
    end
    check("err_saturated", errc[0], 8'hFF);

    // Offset wrap within bank 0 on the BASE_OFS=1020, FRAME_LEN=8 instance
    set_sw(1'b0);
    fill(1'b0, 1020, 8, 12'h7F8);
    run_frame(1, 1'b0, 1020, 8, 8'hFF, 2'b00);
    check("b_err", errc[1], 8'h00);

    // Reset mid-frame with start held high
    fill(1'b0, 0, 16, 12'h7F8);
    @(negedge clk);
    start[0]  = 1'b1;
    iready[0] = 1'b1;
    begin
      int acc = 0;
      for (int cyc = 0; cyc < 200 && acc < 5; cyc++) begin
        @(negedge clk);
        if (ovalid[0]) acc++;
      end
      check("mid_accepts", acc, 5);
    end
    rst = 1'b1;
    #1;
    check("mr_re", re[0], 1'b0);
    check("mr_addr", rd_addr[0], 11'h000);
    check("mr_data", odata[0], 8'h00);
    check("mr_ovalid", ovalid[0], 1'b0);
    check("mr_busy", busy[0], 1'b0);
    check("mr_err", errc[0], 8'h00);
    err_exp = 0;
    @(negedge clk);
    check("mr_done", fdone[0], 1'b0);
    check("mr_busy_hold", busy[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_re", re[0], 1'b1);
    check("restart_addr", rd_addr[0], 11'h000);
    check("restart_busy", busy[0], 1'b1);
    start[0] = 1'b0;
    drain(0);
    check("restart_err", errc[0], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
